// File: rtl/spawn_pkg.sv
// Shared types for the 2-Cars obstacle spawner: lane/kind encoding and
// the event record carried through the spawn FIFO.
package spawn_pkg;

    localparam int   LANE_W      = 2;
    localparam logic KIND_CIRCLE = 1'b0;
    localparam logic KIND_SQUARE = 1'b1;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic              kind;
    } spawn_evt_t;

    localparam int EVT_W = $bits(spawn_evt_t);

endpackage

// File: rtl/spawn_fifo.sv
// Synchronous FIFO of spawn events with a valid/ready read port.
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
module spawn_fifo
    import spawn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  spawn_evt_t       din,
    output logic             valid,
    input  logic             ready,
    output spawn_evt_t       head,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    spawn_evt_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             pop;
    logic             accept;

    assign valid = (count != '0);
    assign full  = (count == LVL_W'(DEPTH));
    assign pop   = valid && ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept = push && (!full || pop);
    assign level  = count;
    // Masked while empty so the outputs read zero after reset.
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Samples the random stream once every PERIOD frames, decides spawn/skip
// with a bounded gap, and queues spawn events for the renderer.
module obstacle_spawner
    import spawn_pkg::*;
#(
    parameter int RAND_W  = 5,
    parameter int PERIOD  = 24,
    parameter int MAX_GAP = 3,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              clear_ovf,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [LANE_W-1:0] spawn_lane,
    output logic              spawn_kind,
    output logic [2:0]        level,
    output logic              ovf
);

    localparam int FC_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int GAP_W = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [FC_W-1:0]  frame_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             decision;
    logic             skip;
    logic             push;
    logic             full;
    logic             pop;
    spawn_evt_t       evt;
    spawn_evt_t       head;
    logic [LVL_W-1:0] fifo_level;
    logic             unused_rand;

    assign unused_rand = ^rand_in;

    assign decision = enable && frame_tick && (frame_cnt == FC_W'(PERIOD - 1));
    // Forced spawn once MAX_GAP skips have happened in a row.
    assign skip     = decision && (rand_in[4:3] == 2'b00) && (gap_cnt < GAP_W'(MAX_GAP));
    assign push     = decision && !skip;
    assign evt.lane = rand_in[1:0];
    assign evt.kind = rand_in[2];
    assign pop      = spawn_valid && spawn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (enable && frame_tick) begin
            if (frame_cnt == FC_W'(PERIOD - 1))
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (skip)
            gap_cnt <= gap_cnt + GAP_W'(1);
        else if (push)
            gap_cnt <= '0;
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (push && full && !pop)
            ovf <= 1'b1;
        else if (clear_ovf)
            ovf <= 1'b0;
    end

    spawn_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt),
        .valid (spawn_valid),
        .ready (spawn_ready),
        .head  (head),
        .full  (full),
        .level (fifo_level)
    );

    assign spawn_lane = head.lane;
    assign spawn_kind = head.kind;
    assign level      = 3'(fifo_level);

endmodule
